// File: rtl/img_mem_writer.sv
// HPS register slave that queues pixel writes and runs linear fills
// into the image memory write port read by the VGA display.
module img_mem_writer #(
   parameter int ADDR_W     = 16,
   parameter int PIX_W      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [3:0]        address,
   input  logic [7:0]        writedata,
   output logic [7:0]        readdata,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_din
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + PIX_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_FILL  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_stage_q, addr_stage_d;
   logic [15:0]       fill_len_q, fill_len_d;
   logic              autoinc_q, autoinc_d;
   logic              ovf_q, ovf_d;
   logic              ferr_q, ferr_d;
   logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
   logic [15:0]       fill_rem_q, fill_rem_d;
   logic [PIX_W-1:0]  fill_val_q, fill_val_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [EW-1:0]     fifo_q [FIFO_DEPTH];
   logic [7:0]        rdata_q, rdata_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [PIX_W-1:0]  mem_din_q, mem_din_d;

   logic wr_en, rd_en;
   logic wr_alo, wr_ahi, wr_pix, wr_llo, wr_lhi;
   logic wr_go, wr_ctrl, wr_clr;
   logic fifo_empty, fifo_full, fill_busy;
   logic push_ok, fifo_pop, fill_issue;
   logic [EW-1:0] head;
   logic [7:0] status;

   assign wr_en   = chipselect & write;
   assign rd_en   = chipselect & read;
   assign wr_alo  = wr_en && (address == 4'd0);
   assign wr_ahi  = wr_en && (address == 4'd1);
   assign wr_pix  = wr_en && (address == 4'd2);
   assign wr_llo  = wr_en && (address == 4'd3);
   assign wr_lhi  = wr_en && (address == 4'd4);
   assign wr_go   = wr_en && (address == 4'd5);
   assign wr_ctrl = wr_en && (address == 4'd6);
   assign wr_clr  = wr_en && (address == 4'd7);

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
   assign fill_busy  = (state_q != S_IDLE);

   // Fill owns the port while running; FIFO issues in IDLE and DRAIN
   assign fill_issue = mem_ready && (state_q == S_FILL);
   assign fifo_pop   = mem_ready && (state_q != S_FILL) && !fifo_empty;
   assign push_ok    = wr_pix && !fifo_full;
   assign head       = fifo_q[rd_ptr_q];

   assign status = {3'b000, ferr_q, ovf_q, fill_busy,
                    fifo_full, fifo_empty};

   always_comb begin
      addr_stage_d = addr_stage_q;
      fill_len_d   = fill_len_q;
      autoinc_d    = autoinc_q;
      if (wr_alo) addr_stage_d[7:0]  = writedata;
      if (wr_ahi) addr_stage_d[15:8] = writedata;
      if (wr_pix && autoinc_q) addr_stage_d = addr_stage_q + 1'b1;
      if (wr_llo) fill_len_d[7:0]  = writedata;
      if (wr_lhi) fill_len_d[15:8] = writedata;
      if (wr_ctrl) autoinc_d = writedata[0];
   end

   always_comb begin
      ovf_d  = ovf_q;
      ferr_d = ferr_q;
      if (wr_clr && writedata[3]) ovf_d  = 1'b0;
      if (wr_clr && writedata[4]) ferr_d = 1'b0;
      if (wr_pix && fifo_full) ovf_d = 1'b1;
      if (wr_go && fill_busy) ferr_d = 1'b1;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, fifo_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      fill_rem_d  = fill_rem_q;
      fill_val_d  = fill_val_q;
      unique case (state_q)
         S_IDLE: begin
            if (wr_go && (fill_len_q != '0)) begin
               state_d     = S_DRAIN;
               fill_addr_d = addr_stage_q;
               fill_rem_d  = fill_len_q;
               fill_val_d  = writedata[PIX_W-1:0];
            end
         end
         S_DRAIN: begin
            if (fifo_empty && !mem_we_q) state_d = S_FILL;
         end
         S_FILL: begin
            if (fill_issue) begin
               fill_addr_d = fill_addr_q + 1'b1;
               fill_rem_d  = fill_rem_q - 1'b1;
               if (fill_rem_q == 16'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      unique case (1'b1)
         fill_issue: begin
            mem_we_d   = 1'b1;
            mem_addr_d = fill_addr_q;
            mem_din_d  = fill_val_q;
         end
         fifo_pop: begin
            mem_we_d   = 1'b1;
            mem_addr_d = head[EW-1:PIX_W];
            mem_din_d  = head[PIX_W-1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         unique case (address)
            4'd0:    rdata_d = status;
            4'd1:    rdata_d = {{(8-CW){1'b0}}, cnt_q};
            4'd6:    rdata_d = {7'b0, autoinc_q};
            default: rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else if (push_ok) begin
         fifo_q[wr_ptr_q] <= {addr_stage_q, writedata[PIX_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_stage_q <= '0;
         fill_len_q   <= '0;
         autoinc_q    <= 1'b0;
         ovf_q        <= 1'b0;
         ferr_q       <= 1'b0;
         fill_addr_q  <= '0;
         fill_rem_q   <= '0;
         fill_val_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_stage_q <= addr_stage_d;
         fill_len_q   <= fill_len_d;
         autoinc_q    <= autoinc_d;
         ovf_q        <= ovf_d;
         ferr_q       <= ferr_d;
         fill_addr_q  <= fill_addr_d;
         fill_rem_q   <= fill_rem_d;
         fill_val_q   <= fill_val_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
      end
   end

   assign readdata = rdata_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_img_mem_writer.sv
// Directed bench for img_mem_writer with a scoreboard of expected
// memory writes checked as the DUT issues them.
module tb_img_mem_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        chipselect, write, read;
   logic [3:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        mem_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [3:0]  mem_din;

   always #5 clk = ~clk;

   img_mem_writer #(.ADDR_W(16), .PIX_W(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata),
      .readdata(readdata), .mem_ready(mem_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [3:0]  d;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          n_writes = 0;
   logic [15:0] addr_m;
   logic        autoinc_m;
   logic [7:0]  rv;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         n_writes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL mem_unexpected observed=0x%0h/0x%0h expected=none",
                   mem_addr, mem_din);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("mem_addr", {16'h0, mem_addr}, {16'h0, mon_e.a});
            check("mem_din", {28'h0, mem_din}, {28'h0, mon_e.d});
         end
      end
   end

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a,
                         input logic [7:0] exp);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      rv = readdata;
      check(tag, {24'h0, rv}, {24'h0, exp});
   endtask

   task automatic set_addr(input logic [15:0] a);
      wr(4'd0, a[7:0]);
      wr(4'd1, a[15:8]);
      addr_m = a;
   endtask

   task automatic pix(input logic [3:0] d, input bit accepted);
      if (accepted) exp_q.push_back('{a: addr_m, d: d});
      wr(4'd2, {4'h0, d});
      if (autoinc_m) addr_m = addr_m + 16'd1;
   endtask

   task automatic fill(input logic [15:0] len, input logic [3:0] v);
      for (int i = 0; i < int'(len); i++)
         exp_q.push_back('{a: addr_m + 16'(i), d: v});
      wr(4'd5, {4'h0, v});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      bit hit;
      reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0; mem_ready = 1'b0;
      addr_m = '0; autoinc_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", {31'h0, mem_we}, 32'h0);
      check("rst_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_din", {28'h0, mem_din}, 32'h0);
      check("rst_rdata", {24'h0, readdata}, 32'h0);
      reset_n = 1'b1;
      idle(1);
      rd_chk("rst_status", 4'd0, 8'h01);

      // Autoinc pixel writes
      mem_ready = 1'b1;
      set_addr(16'h1234);
      wr(4'd6, 8'h01); autoinc_m = 1'b1;
      pix(4'h5, 1); pix(4'h6, 1); pix(4'h7, 1);
      idle(4);
      check("t1_drained", exp_q.size(), 0);
      rd_chk("t1_status", 4'd0, 8'h01);
      rd_chk("t1_ctrl", 4'd6, 8'h01);
      pix(4'h8, 1);
      idle(4);

      // Overflow with stalled memory
      mem_ready = 1'b0;
      for (int i = 0; i < 9; i++) pix(4'(i), i < 8);
      rd_chk("t2_count", 4'd1, 8'h08);
      rd_chk("t2_status_ovf", 4'd0, 8'h0A);
      wr(4'd7, 8'h08);
      rd_chk("t2_status_clr", 4'd0, 8'h02);
      mem_ready = 1'b1;
      idle(12);
      check("t2_drained", exp_q.size(), 0);
      rd_chk("t2_status_end", 4'd0, 8'h01);

      // Wrapping fill with exact latency
      set_addr(16'hFFFE);
      wr(4'd3, 8'h04); wr(4'd4, 8'h00);
      fill(16'd4, 4'hA);
      @(negedge clk);
      check("t3_lat_n", {31'h0, mem_we}, 32'h0);
      @(negedge clk);
      check("t3_lat_n1", {31'h0, mem_we}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_we_run", {31'h0, mem_we}, 32'h1);
      end
      @(negedge clk);
      check("t3_we_end", {31'h0, mem_we}, 32'h0);
      idle(1);
      rd_chk("t3_status", 4'd0, 8'h01);
      pix(4'h3, 1);
      idle(4);
      check("t3_drained", exp_q.size(), 0);

      // FIFO drains ahead of a fill; re-trigger flags an error
      mem_ready = 1'b0;
      set_addr(16'h0100);
      pix(4'h1, 1); pix(4'h2, 1);
      wr(4'd3, 8'h03); wr(4'd4, 8'h00);
      fill(16'd3, 4'hC);
      rd_chk("t4_status_busy", 4'd0, 8'h04);
      mem_ready = 1'b1;
      idle(4);
      wr(4'd5, 8'h07);
      idle(10);
      check("t4_drained", exp_q.size(), 0);
      rd_chk("t4_status_err", 4'd0, 8'h11);
      wr(4'd7, 8'h10);
      rd_chk("t4_status_clr", 4'd0, 8'h01);

      // Zero-length fill is a no-op
      wr(4'd3, 8'h00); wr(4'd4, 8'h00);
      wr(4'd5, 8'h03);
      @(negedge clk);
      check("t5_we", {31'h0, mem_we}, 32'h0);
      idle(1);
      rd_chk("t5_status", 4'd0, 8'h01);
      idle(3);

      // Reset during a long fill
      set_addr(16'h2000);
      wr(4'd3, 8'd100); wr(4'd4, 8'h00);
      base = n_writes;
      fill(16'd100, 4'h9);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #1;
         if (n_writes - base >= 10) hit = 1'b1;
      end
      check("t6_reach10", {31'h0, hit}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_we", {31'h0, mem_we}, 32'h0);
      check("t6_rst_addr", {16'h0, mem_addr}, 32'h0);
      exp_q.delete();
      addr_m = '0; autoinc_m = 1'b0;
      base = n_writes;
      idle(2);
      reset_n = 1'b1;
      idle(1);
      rd_chk("t6_status", 4'd0, 8'h01);
      rd_chk("t6_count", 4'd1, 8'h00);
      rd_chk("t6_ctrl", 4'd6, 8'h00);
      idle(20);
      check("t6_no_writes", n_writes - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/img_mem_writer.md
Name: img_mem_writer

Overview:
- HPS-facing Avalon-MM register slave that turns 8-bit HPS register writes into pixel writes on the image memory write port.
- Pixels go into the image memory, which the VGA display reads; this block is the writing end of that memory.
- Holds a small command FIFO for single pixel writes and a fill engine for rectangular-free linear fills (clears, solid runs).
- Reports status back to the HPS over a 1-cycle-latency read path.

Parameters:
- ADDR_W, 16, image memory address width (fixed at 16 by the register map).
- PIX_W, 4, pixel data width (≤8).
- FIFO_DEPTH, 8, pixel command FIFO entries (power of two).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe (qualified by chipselect)
- read  in  1  Avalon read strobe (qualified by chipselect)
- address  in  4  register index
- writedata  in  8  register write data
- readdata  out  8  register read data, valid the cycle after read
- mem_ready  in  1  image memory grants a write slot next cycle
- mem_we  out  1  image memory write enable, one pixel per high cycle
- mem_addr  out  ADDR_W  image memory write address
- mem_din  out  PIX_W  image memory write data

Behaviour:
- Reset: all outputs 0; FIFO empty; addr_stage=0; fill_len=0; ctrl=0; sticky bits 0; FSM in IDLE. Reset takes effect immediately at any point, including mid-fill; any in-progress fill is abandoned.
- Write register map (write && chipselect):
  - 0 ADDR_LO: addr_stage[7:0]=writedata.
  - 1 ADDR_HI: addr_stage[15:8]=writedata.
  - 2 PIXEL: push {addr_stage, writedata[PIX_W-1:0]}. If ctrl.autoinc=1, addr_stage+=1, wrapping 0xFFFF→0x0000.
  - 3 FILL_LEN_LO: fill_len[7:0]=writedata.
  - 4 FILL_LEN_HI: fill_len[15:8]=writedata.
  - 5 FILL_GO: start a fill of fill_len pixels with value writedata[PIX_W-1:0], starting at addr_stage.
  - 6 CTRL: bit0 is autoinc.
  - 7 CLEAR: writing 1 to bit3 clears overflow; writing 1 to bit4 clears fill_err.
- Read register map: readdata registers on the edge after read && chipselect; readdata holds its value otherwise.
  - 0 STATUS: {3'b0, fill_err, overflow, fill_busy, fifo_full, fifo_empty}.
  - 1 FIFO count.
  - 6 CTRL.
  - All other addresses read 0.
- FIFO push rule: fifo_full is sampled before this cycle's pop. A push while full is dropped and sets overflow (sticky); autoinc still applies. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states:
  - IDLE → DRAIN on FILL_GO with fill_len≠0. FILL_GO with fill_len=0 is a no-op.
  - DRAIN → FILL when the FIFO is empty and no mem write is pending.
  - FILL → IDLE after the last pixel is issued.
- FILL_GO while in DRAIN or FILL is ignored and sets fill_err (sticky).
- fill_busy=1 in DRAIN and FILL.
- At FILL_GO the block snapshots the start address, length and value. Later ADDR and LEN writes do not affect the running fill, and the fill never modifies addr_stage.
- Memory port arbitration, evaluated each edge: if mem_ready=1, one source is issued.
  - In FILL, the fill engine issues; FIFO pops are blocked, and PIXEL pushes still enqueue.
  - Otherwise the FIFO head issues if the FIFO is non-empty.
  - On issue, mem_we<=1 and mem_addr/mem_din<=source values; otherwise mem_we<=0.
  - mem_addr/mem_din hold their last values when mem_we=0.
- Fill addressing: the fill address increments per issued pixel and wraps at 0xFFFF.
- Latency:
  - PIXEL write at edge N, with FIFO previously empty and mem_ready=1 → mem_we=1 after edge N+1.
  - FILL_GO at edge N, with FIFO empty → DRAIN after N, FILL after N+1, first mem_we after N+2.
  - With mem_ready held high, a fill of L pixels produces exactly L consecutive mem_we cycles.
- mem_ready low stalls all issue with no loss: FIFO contents and fill position are retained.

Test Plan:
- Reset, then write ADDR_LO=0x34, ADDR_HI=0x12, CTRL=1, then PIXEL 0x5,0x6,0x7 with mem_ready=1 → three mem_we pulses at addr 0x1234/0x1235/0x1236 with din 5/6/7; addr_stage=0x1237; STATUS reads 0x01.
- mem_ready=0, nine PIXEL writes with DEPTH 8 → count=8, STATUS=0x0A, ninth dropped. Then write CLEAR=0x08, raise mem_ready → eight writes, STATUS=0x01.
- ADDR=0xFFFE, FILL_LEN=4, FILL_GO=0xA → writes to 0xFFFE,0xFFFF,0x0000,0x0001 with din 0xA on 4 consecutive cycles; fill_busy returns to 0; addr_stage remains 0xFFFE.
- Two PIXEL writes queued with mem_ready=0, then FILL_GO (len 3), then mem_ready=1 → both FIFO pixels issue first, then three fill pixels; a second FILL_GO during FILL sets STATUS bit4 and causes no extra writes.
- FILL_GO with fill_len=0 → no mem_we, fill_busy stays 0, fill_err stays 0.
- Start a 100-pixel fill, assert reset_n=0 after 10 writes → mem_we drops to 0 immediately; after release, STATUS=0x01 and no further writes occur.
